// File: rtl/fp_conv_arbiter_pkg.sv
// Shared types for the FP converter arbiter: converter command/flag types,
// arbiter state encoding and requester identifiers.
package fp_conv_arbiter_pkg;

   typedef logic [31:0] word_t;
   typedef logic [63:0] uint64_t;
   typedef logic [4:0]  fflags_t;

   typedef enum logic [2:0] {
      FCVT_W_D  = 3'd0,
      FCVT_WU_D = 3'd1,
      FCVT_D_W  = 3'd2,
      FCVT_D_WU = 3'd3,
      FMV_X_D   = 3'd4,
      FMV_D_X   = 3'd5
   } FpConverterCommand;

   localparam int FP_CMD_W = $bits(FpConverterCommand);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } FpConvArbState;

   typedef logic FpConvRequesterId;

   localparam int FP_CONV_REQUESTERS = 2;

endpackage

// File: rtl/fp_conv_rr_picker.sv
// Two-way round-robin picker: the pointer only breaks ties when both
// requesters are valid, otherwise the single valid requester wins.
module fp_conv_rr_picker
   import fp_conv_arbiter_pkg::*;
(
   input  logic [FP_CONV_REQUESTERS-1:0] valid_i,
   input  logic                          pointer_i,
   output logic                          grant_valid_o,
   output logic                          grant_id_o
);

   assign grant_valid_o = |valid_i;
   assign grant_id_o    = (&valid_i) ? pointer_i : valid_i[1];

endmodule

// File: rtl/fp_conv_arbiter.sv
// Sequencer and two-way arbiter in front of the shared FP converter: grants,
// latches operands, waits the converter settle time and holds the result.
module fp_conv_arbiter
   import fp_conv_arbiter_pkg::*;
#(
   parameter int LATENCY = 2
)
(
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        flush,
   input  logic [FP_CONV_REQUESTERS-1:0]               req_valid,
   output logic [FP_CONV_REQUESTERS-1:0]               req_ready,
   input  logic [FP_CONV_REQUESTERS-1:0][FP_CMD_W-1:0] req_command,
   input  logic [FP_CONV_REQUESTERS-1:0][2:0]          req_rounding_mode,
   input  logic [FP_CONV_REQUESTERS-1:0][31:0]         req_int_src,
   input  logic [FP_CONV_REQUESTERS-1:0][63:0]         req_fp_src,
   output logic [FP_CONV_REQUESTERS-1:0]               resp_valid,
   input  logic [FP_CONV_REQUESTERS-1:0]               resp_ready,
   output logic [31:0]                                 resp_int_result,
   output logic [63:0]                                 resp_fp_result,
   output logic [4:0]                                  resp_flags,
   output logic [FP_CMD_W-1:0]                         conv_command,
   output logic [2:0]                                  conv_rounding_mode,
   output logic [31:0]                                 conv_int_src,
   output logic [63:0]                                 conv_fp_src,
   input  logic [31:0]                                 conv_int_result,
   input  logic [63:0]                                 conv_fp_result,
   input  logic [4:0]                                  conv_flags
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   FpConvArbState    state_q, state_d;
   FpConvRequesterId pointer_q;
   FpConvRequesterId owner_q;
   logic [3:0]       count_q, count_d;

   logic [FP_CMD_W-1:0] cmd_q;
   logic [2:0]          rm_q;
   word_t               int_src_q;
   uint64_t             fp_src_q;
   word_t               res_int_q;
   uint64_t             res_fp_q;
   fflags_t             res_flags_q;

   logic grant_valid;
   logic grant_id;
   logic accept;
   logic capture;

   fp_conv_rr_picker u_picker (
      .valid_i       (req_valid),
      .pointer_i     (pointer_q),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   // rst is included so req_ready reads 0 for the whole reset pulse.
   assign accept    = (state_q == IDLE) && !flush && !rst && grant_valid;
   assign capture   = (state_q == BUSY) && (count_q == 4'd0) && !flush;
   assign req_ready = accept ? (2'b01 << grant_id) : 2'b00;
   assign resp_valid = (state_q == RESP) ? (2'b01 << owner_q) : 2'b00;

   assign conv_command       = cmd_q;
   assign conv_rounding_mode = rm_q;
   assign conv_int_src       = int_src_q;
   assign conv_fp_src        = fp_src_q;
   assign resp_int_result    = res_int_q;
   assign resp_fp_result     = res_fp_q;
   assign resp_flags         = res_flags_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               count_d = LAT_M1;
            end
         end
         BUSY: begin
            if (count_q == 4'd0) begin
               state_d = RESP;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Flush wins over capture and over a same-cycle result handshake.
      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pointer_q   <= 1'b0;
         owner_q     <= 1'b0;
         count_q     <= 4'd0;
         cmd_q       <= '0;
         rm_q        <= '0;
         int_src_q   <= '0;
         fp_src_q    <= '0;
         res_int_q   <= '0;
         res_fp_q    <= '0;
         res_flags_q <= '0;
      end else begin
         count_q <= count_d;
         if (accept) begin
            owner_q   <= grant_id;
            pointer_q <= ~grant_id;
            cmd_q     <= req_command[grant_id];
            rm_q      <= req_rounding_mode[grant_id];
            int_src_q <= req_int_src[grant_id];
            fp_src_q  <= req_fp_src[grant_id];
         end
         if (capture) begin
            res_int_q   <= conv_int_result;
            res_fp_q    <= conv_fp_result;
            res_flags_q <= conv_flags;
         end
      end
   end

endmodule

// File: doc/fp_conv_arbiter.md
# fp_conv_arbiter

Sequencer and two-way arbiter for the shared FP converter datapath (FCVT/FMV int↔fp). Grants one of two requesters (0 = integer execute pipe, 1 = FP execute pipe) round-robin, latches its operands, drives the converter for a fixed settle latency, captures the result, and holds it until the owning requester accepts it. Sits between the execute stages and the single FpConverter instance; supports flush from the pipeline controller.

## Interface
- LATENCY, default 2: cycles the converter needs after operands are applied; legal range 1..15.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  abort any in-flight or held operation.
- req_valid  in  2  per-requester request.
- req_ready  out  2  per-requester grant/accept.
- req_command  in  2 x FpConverterCommand  per-requester conversion command.
- req_rounding_mode  in  2 x 3  per-requester rounding mode.
- req_int_src  in  2 x 32  per-requester integer operand (word_t).
- req_fp_src  in  2 x 64  per-requester FP operand (uint64_t).
- resp_valid  out  2  result valid, only the owner's bit.
- resp_ready  in  2  per-requester result accept.
- resp_int_result  out  32  held integer result, shared.
- resp_fp_result  out  64  held FP result, shared.
- resp_flags  out  5  held fflags_t, shared.
- conv_command  out  FpConverterCommand  to converter.
- conv_rounding_mode  out  3  to converter.
- conv_int_src  out  32  to converter.
- conv_fp_src  out  64  to converter.
- conv_int_result  in  32  from converter.
- conv_fp_result  in  64  from converter.
- conv_flags  in  5  from converter.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if flush=0 and any req_valid, grant one requester. If both are valid, grant the requester pointed to by the priority pointer (reset 0). If only one is valid, grant it. req_ready[grant]=1 combinationally and at most one bit is set. On the edge: latch the operands, set owner=grant, set pointer=~grant, set count=LATENCY-1, go to BUSY.
- BUSY: conv_* outputs are driven from the latched operands and stay stable. Decrement count each cycle. When count=0, capture conv_int_result, conv_fp_result and conv_flags into the resp registers and go to RESP.
- RESP: resp_valid[owner]=1. When resp_ready[owner]=1, go to IDLE. resp_ready on the non-owner bit is ignored.
- req_ready=0 whenever the state is not IDLE, when flush=1, or while rst=1.
- flush in BUSY or RESP: go to IDLE on the next edge; no response is issued and the pointer is unchanged. flush takes precedence over a simultaneous resp handshake or capture.
- No bypass: a new grant happens no earlier than the cycle after the RESP handshake.
- Reset values:
  - state IDLE, pointer 0, owner 0, count 0.
  - latched operands 0, so all conv_* outputs are 0.
  - resp_valid 0; resp_int_result, resp_fp_result and resp_flags 0.
- Reset asserted mid-operation drops the operation immediately; no response is issued.

## Timing
- Accept on edge N. BUSY covers cycles N+1 .. N+LATENCY. Capture on edge N+LATENCY+1, with resp_valid high from that point.
- Accept-to-resp_valid latency: LATENCY+1 cycles.
- Minimum occupancy per operation: LATENCY+2 cycles. This assumes the result is accepted in its first cycle of resp_valid; throughput is therefore one result per LATENCY+2 cycles.
- resp_* outputs remain stable while resp_valid=1.
- The count register is 4 bits.

## Structure
- A shared package (OpTypes) holds:
  - the FpConvArbState enum (IDLE/BUSY/RESP);
  - the FpConvRequesterId typedef (1 bit);
  - the FP_CONV_REQUESTERS=2 constant.
- FpConverterCommand, fflags_t, word_t and uint64_t come from the existing packages.
- One sub-module, fp_conv_rr_picker, is natural: a combinational two-way round-robin picker with inputs valid[2] and pointer, and outputs grant_valid and grant_id.
- The top level holds the FSM, the counter, and the operand and result registers.

## Test plan
- Single request, LATENCY=2: req_valid=01, command int→fp, int_src=32'd5 at cycle 0 → req_ready=01 at cycle 0; resp_valid=01 at cycle 3 with resp_fp_result equal to the converter output for 5; IDLE after resp_ready.
- Contention: req_valid=11 held continuously with immediate resp_ready → grants alternate 0,1,0,1 starting from reset pointer 0; each resp_valid goes only to the owner's bit.
- Backpressure: resp_ready=0 for 4 cycles in RESP → resp_valid and resp_* held stable for all 4 cycles; req_ready stays 00 throughout; one handshake then IDLE.
- Flush in BUSY at cycle 1 → no resp_valid ever; next request accepted the cycle after flush; pointer unchanged, so requester 0 wins if both are valid.
- Async reset asserted in RESP, mid-cycle → resp_valid drops to 0 without waiting for a clock edge; conv_* outputs read 0; req_ready stays 00 until rst is deasserted.
- LATENCY=1 and LATENCY=15 → resp_valid arrives exactly 2 and 16 cycles after accept respectively.
